// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-shared FIR and its feeder.
// Defaults here match the FIR so both sides agree on the result width.
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_COEFF_WIDTH = 16;
  localparam int FIR_COEFF_FRACTION_WIDTH = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESULT,
    HOLD
  } feeder_state_t;

  function automatic int fir_result_width(
    input int dw,
    input int cw,
    input int fw
  );
    return dw + cw - fw + 2;
  endfunction

endpackage

// File: rtl/fir_share_feeder_if.sv
// Upstream sample stream and downstream result stream of the FIR feeder.
// slave = feeder side, master = producer/consumer side.
interface fir_share_feeder_if
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int RW = fir_result_width(
    FIR_DATA_WIDTH,
    FIR_COEFF_WIDTH,
    FIR_COEFF_FRACTION_WIDTH
  )
);

  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         s_valid;
  logic                         s_ready;
  logic signed [RW-1:0]         m_data;
  logic                         m_valid;
  logic                         m_ready;

  modport slave (
    input  s_data,
    input  s_valid,
    input  m_ready,
    output s_ready,
    output m_data,
    output m_valid
  );

  modport master (
    output s_data,
    output s_valid,
    output m_ready,
    input  s_ready,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/fir_feeder_fifo.sv
// Small synchronous FIFO; full is a flop so the feeder's s_ready is registered.
// Writes while full are refused even if a pop lands in the same cycle.
module fir_feeder_fifo
  import fir_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_comb begin
    cnt_d = count;
    if (do_push && !do_pop) cnt_d = count + CNT_ONE;
    if (!do_push && do_pop) cnt_d = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      count <= cnt_d;
      full <= (cnt_d == CNT_FULL);
    end
  end

endmodule

// File: rtl/fir_share_feeder.sv
// Sequencer feeding one sample at a time to the time-shared 4-tap FIR.
// Optional watchdog in WAIT_RESULT: define FEEDER_TIMEOUT_EN.
module fir_share_feeder
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
  parameter int COEFF_FRACTION_WIDTH = FIR_COEFF_FRACTION_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int RW = fir_result_width(
    DATA_WIDTH,
    COEFF_WIDTH,
    COEFF_FRACTION_WIDTH
  ),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  fir_share_feeder_if.slave            bus,
  output logic signed [DATA_WIDTH-1:0] fir_data,
  output logic                         fir_data_valid,
  input  logic signed [RW-1:0]         fir_out_sum,
  input  logic                         fir_out_valid,
  output logic [CW-1:0]                fifo_count,
  output logic                         err_spurious,
  output logic                         err_timeout
);

  feeder_state_t         state;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;

  assign push = bus.s_valid && bus.s_ready;
  assign pop = (state == IDLE) && !empty;
  assign bus.s_ready = !full;

  fir_feeder_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  logic [TW-1:0] tmr;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fir_data <= '0;
      fir_data_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_valid <= 1'b0;
      err_spurious <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      err_timeout <= 1'b0;
      tmr <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (fir_out_valid) err_spurious <= 1'b1;
          if (!empty) begin
            fir_data <= head;
            fir_data_valid <= 1'b1;
            state <= WAIT_RESULT;
`ifdef FEEDER_TIMEOUT_EN
            tmr <= '0;
`endif
          end
        end
        WAIT_RESULT: begin
          fir_data_valid <= 1'b0;
          // a result on the expiry cycle still wins
          if (fir_out_valid) begin
            bus.m_data <= fir_out_sum;
            bus.m_valid <= 1'b1;
            state <= HOLD;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (tmr == T_LAST) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end else begin
            tmr <= tmr + T_ONE;
          end
`endif
        end
        HOLD: begin
          if (fir_out_valid) err_spurious <= 1'b1;
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_share_feeder.md
Name: fir_share_feeder

Overview:
- Initiator-side sequencer for the time-shared 4-tap FIR (fir_4_tap_hardware_share).
- Buffers upstream samples from a valid/ready stream in a small FIFO.
- Issues one sample at a time to the FIR as a single-cycle valid pulse, then waits for the FIR's result valid.
- Presents each result on a valid/ready output with backpressure, so upstream never has to track the FIR's multi-cycle MAC schedule.

Parameters:
- DATA_WIDTH, 16, sample width (signed).
- COEFF_WIDTH, 16, FIR coefficient width; used only to size the result.
- COEFF_FRACTION_WIDTH, 15, coefficient fraction bits; used only to size the result.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 16, watchdog limit in WAIT_RESULT; used only with FEEDER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- s_data  in  DATA_WIDTH  upstream sample, signed.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO not full.
- fir_data  out  DATA_WIDTH  sample to FIR i_data.
- fir_data_valid  out  1  single-cycle pulse to FIR i_data_valid.
- fir_out_sum  in  RW  FIR o_data_sum; RW = DATA_WIDTH+COEFF_WIDTH-COEFF_FRACTION_WIDTH+2 (19 at defaults).
- fir_out_valid  in  1  FIR o_data_valid.
- m_data  out  RW  captured result, signed.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- err_spurious  out  1  sticky flag: fir_out_valid seen outside WAIT_RESULT.
- err_timeout  out  1  sticky flag: watchdog expired.

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except s_ready=1; FIFO emptied; state IDLE; sticky flags cleared. Reset mid-transaction discards the in-flight sample and any held result.
- FIFO:
  - Push on s_valid&&s_ready. Pop only on issue.
  - s_ready is registered as !full; no push while full, even if a pop happens the same cycle.
  - A word pushed at cycle t becomes visible to IDLE at t+1.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count tracks push/pop; simultaneous push+pop leaves it unchanged.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty, then fir_data<=head, fir_data_valid<=1, pop, go to WAIT_RESULT. Else stay.
  - WAIT_RESULT: fir_data_valid<=0. On fir_out_valid, m_data<=fir_out_sum, m_valid<=1, go to HOLD.
  - HOLD: on m_valid&&m_ready, m_valid<=0, go to IDLE.
- Exactly one FIR transaction is in flight at a time. fir_data_valid is never high for two consecutive cycles.
- Latency: sample accepted at t gives fir_data_valid high at t+2. The FIR result arrives 5 cycles after its valid pulse. The bench does not rely on the exact FIR latency; the feeder only waits on fir_out_valid.
- m_data and m_valid hold stable while m_valid&&!m_ready. During HOLD, the FIFO keeps accepting input.
- fir_out_valid in IDLE or HOLD: ignored, err_spurious<=1 (sticky until reset).
- No arithmetic on fir_out_sum; it is passed through at full width RW.

Optional Feature:
- Macro FEEDER_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT_RESULT, incremented each WAIT_RESULT cycle.
  - Reaching TIMEOUT_CYCLES without fir_out_valid: err_timeout<=1 (sticky), sample dropped, m_valid stays 0, go to IDLE.
  - fir_out_valid on the expiry cycle wins: the result is captured and the timeout is not flagged.
- Undefined: no counter; WAIT_RESULT waits indefinitely; err_timeout tied to 0.

Decomposition:
- Shared package fir_pkg:
  - state enum {IDLE, WAIT_RESULT, HOLD}.
  - Function for the result width RW.
  - Default width constants shared with the FIR.
- One sub-module: fir_feeder_fifo (parameterised sync FIFO with push/pop/full/empty/count).

Test Plan:
- Reference numbers: stimuli below use coefficients 0.125/0.25/0.25/0.125. The DUT connects to the real FIR.
- Single samples 100, 200, 300, 400 with idle gaps, m_ready=1 → m_data 12, 50, 112, 187 in order. Exactly four fir_data_valid pulses, each one cycle wide.
- Burst of 6 samples with m_ready=1 and FIFO_DEPTH=4 → s_ready drops after 4 entries and reasserts after the first pop. All 6 results come out in order; fifo_count never exceeds 4.
- m_ready held 0 for 20 cycles after the first result → m_data=12 and m_valid stay stable; no second fir_data_valid until m_ready=1. The next result then follows.
- fir_out_valid forced high in IDLE → err_spurious=1; m_valid stays 0; normal traffic afterwards still produces 12.
- With FEEDER_TIMEOUT_EN, FIR replaced by a non-responding stub → err_timeout=1 exactly 16 cycles after the pulse; FSM returns to IDLE and issues the next queued sample.
- Reset asserted in WAIT_RESULT with 3 samples queued → next cycle fifo_count=0, m_valid=0, s_ready=1, flags 0; the following sample 100 yields 12.
